// File: rtl/regfile_scoreboard_if.sv
// Issue-stage <-> register file bundle: two read ports, one write port, one reserve port.
// The master drives addresses, write and reserve requests; the slave returns data, busy flags and busy count.
interface regfile_scoreboard_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rd_addr1;
   logic [ADDR_W-1:0] rd_addr2;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;
   logic              rd_busy1;
   logic              rd_busy2;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_addr;
   logic [ADDR_W:0]   busy_cnt;

   modport master (
      output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      input  rd_data1, rd_data2, rd_busy1, rd_busy2, busy_cnt
   );

   modport slave (
      input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      output rd_data1, rd_data2, rd_busy1, rd_busy2, busy_cnt
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with zero register, optional write bypass and a pending-write scoreboard.
// Reads are combinational (zero latency); write/reserve commit on the rising edge; no backpressure.
module regfile_scoreboard #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter bit BYPASS = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_scoreboard_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0]  r_busy;
   logic [ADDR_W:0]   r_busy_cnt;

   logic              w_wr_vld;
   logic              w_rsv_vld;
   logic              w_set;
   logic              w_clr;
   logic [ADDR_W-1:0] w_rd_addr [2];
   logic [DATA_W-1:0] w_rd_data [2];
   logic [1:0]        w_rd_busy;

   assign w_wr_vld  = bus.wr_en  && (bus.wr_addr  != '0);
   assign w_rsv_vld = bus.rsv_en && (bus.rsv_addr != '0);

   // Count only real transitions: a reserve on the written register keeps it busy, so no clear.
   assign w_set = w_rsv_vld && !r_busy[bus.rsv_addr];
   assign w_clr = w_wr_vld && r_busy[bus.wr_addr] &&
                  !(w_rsv_vld && (bus.rsv_addr == bus.wr_addr));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         if (w_wr_vld) begin
            r_regs[bus.wr_addr] <= bus.wr_data;
            r_busy[bus.wr_addr] <= 1'b0;
         end
         // Placed after the write so a same-address reserve wins.
         if (w_rsv_vld) begin
            r_busy[bus.rsv_addr] <= 1'b1;
         end
         r_busy_cnt <= r_busy_cnt + (ADDR_W+1)'(w_set) - (ADDR_W+1)'(w_clr);
      end
   end

   assign w_rd_addr[0] = bus.rd_addr1;
   assign w_rd_addr[1] = bus.rd_addr2;

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_rd_data[p] = '0;
         w_rd_busy[p] = 1'b0;
         if (!rst && (w_rd_addr[p] != '0)) begin
            if (BYPASS && w_wr_vld && (bus.wr_addr == w_rd_addr[p])) begin
               w_rd_data[p] = bus.wr_data;
            end else begin
               w_rd_data[p] = r_regs[w_rd_addr[p]];
               w_rd_busy[p] = r_busy[w_rd_addr[p]];
            end
         end
      end
   end

   assign bus.rd_data1 = w_rd_data[0];
   assign bus.rd_data2 = w_rd_data[1];
   assign bus.rd_busy1 = w_rd_busy[0];
   assign bus.rd_busy2 = w_rd_busy[1];
   assign bus.busy_cnt = r_busy_cnt;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Drives a bypassing and a non-bypassing register file with directed then random traffic.
// Both are compared every cycle against an array-based model of the register/busy state.
module tb_regfile_scoreboard;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int N  = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [AW-1:0] t_ra1 = '0, t_ra2 = '0, t_wa = '0, t_sa = '0;
   logic [DW-1:0] t_wd  = '0;
   logic          t_we  = 1'b0, t_se = 1'b0;
   logic          chk_en = 1'b0;
   int            n_vec = 0;
   int            n_err = 0;

   regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
   regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

   assign if0.rd_addr1 = t_ra1;  assign if1.rd_addr1 = t_ra1;
   assign if0.rd_addr2 = t_ra2;  assign if1.rd_addr2 = t_ra2;
   assign if0.wr_en    = t_we;   assign if1.wr_en    = t_we;
   assign if0.wr_addr  = t_wa;   assign if1.wr_addr  = t_wa;
   assign if0.wr_data  = t_wd;   assign if1.wr_data  = t_wd;
   assign if0.rsv_en   = t_se;   assign if1.rsv_en   = t_se;
   assign if0.rsv_addr = t_sa;   assign if1.rsv_addr = t_sa;

   regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b0)) dut0 (
      .clk(clk), .rst(rst), .bus(if0.slave));
   regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1)) dut1 (
      .clk(clk), .rst(rst), .bus(if1.slave));

   // Model: architectural register contents and pending flags; count is a plain popcount.
   logic [DW-1:0] m_regs [N] = '{default: '0};
   logic [N-1:0]  m_busy = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) m_regs[i] = '0;
         m_busy = '0;
      end else begin
         if (t_we && t_wa != 0) begin
            m_regs[t_wa] = t_wd;
            m_busy[t_wa] = 1'b0;
         end
         if (t_se && t_sa != 0) m_busy[t_sa] = 1'b1;
      end
   end

   function automatic logic [DW:0] exp_rd(input bit byp, input logic [AW-1:0] a);
      if (rst || a == 0) return '0;
      if (byp && t_we && t_wa == a) return {1'b0, t_wd};
      return {m_busy[a], m_regs[a]};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         logic [DW:0] e;
         logic [AW:0] c;
         c = rst ? '0 : (AW+1)'($countones(m_busy));
         e = exp_rd(1'b0, t_ra1);
         chk("b0_rd_data1", if0.rd_data1, e[DW-1:0]); chk("b0_rd_busy1", if0.rd_busy1, e[DW]);
         e = exp_rd(1'b0, t_ra2);
         chk("b0_rd_data2", if0.rd_data2, e[DW-1:0]); chk("b0_rd_busy2", if0.rd_busy2, e[DW]);
         e = exp_rd(1'b1, t_ra1);
         chk("b1_rd_data1", if1.rd_data1, e[DW-1:0]); chk("b1_rd_busy1", if1.rd_busy1, e[DW]);
         e = exp_rd(1'b1, t_ra2);
         chk("b1_rd_data2", if1.rd_data2, e[DW-1:0]); chk("b1_rd_busy2", if1.rd_busy2, e[DW]);
         chk("b0_busy_cnt", if0.busy_cnt, c);
         chk("b1_busy_cnt", if1.busy_cnt, c);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 2) == 0) return AW'($urandom_range(0, 3));
      return AW'($urandom_range(0, N-1));
   endfunction

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;

      // Asynchronous reset clears state between edges
      t_we = 1; t_wa = 5; t_wd = 32'h1234; t_se = 1; t_sa = 5; t_ra1 = 5;
      tick();
      t_we = 0; t_se = 0;
      #1;
      chk("pre_rst_data", if1.rd_data1, 32'h1234);
      chk("pre_rst_busy", if1.rd_busy1, 1);
      chk("pre_rst_cnt", if1.busy_cnt, 1);
      rst = 1'b1;
      #1;
      chk("rst_data", if1.rd_data1, 0);
      chk("rst_busy", if1.rd_busy1, 0);
      chk("rst_cnt", if0.busy_cnt, 0);
      #1 rst = 1'b0;

      // Register 0 ignores writes and reserves
      tick();
      t_we = 1; t_wa = 0; t_wd = '1; t_se = 1; t_sa = 0; t_ra1 = 0;
      tick();
      t_we = 0; t_se = 0;
      #1;
      chk("zero_data", if1.rd_data1, 0);
      chk("zero_busy", if1.rd_busy1, 0);
      chk("zero_cnt", if1.busy_cnt, 0);

      // Bypass vs. no bypass
      t_we = 1; t_wa = 3; t_wd = 7;
      tick();
      t_wd = 9; t_ra1 = 3; t_ra2 = 3;
      #1;
      chk("byp1_data1", if1.rd_data1, 9);
      chk("byp1_data2", if1.rd_data2, 9);
      chk("byp0_data1_pre", if0.rd_data1, 7);
      chk("byp0_data2_pre", if0.rd_data2, 7);
      tick();
      t_we = 0;
      #1 chk("byp0_data1_post", if0.rd_data1, 9);

      // Scoreboard reserve / release
      t_se = 1; t_sa = 8;
      tick();
      chk("sb_cnt1", if1.busy_cnt, 1);
      t_sa = 9;
      tick();
      t_se = 0; t_ra1 = 8;
      #1;
      chk("sb_cnt2", if1.busy_cnt, 2);
      chk("sb_busy8", if0.rd_busy1, 1);
      t_we = 1; t_wa = 8; t_wd = 32'h88;
      #1;
      chk("sb_busy8_byp", if1.rd_busy1, 0);
      chk("sb_busy8_nobyp", if0.rd_busy1, 1);
      tick();
      t_we = 0;
      #1;
      chk("sb_cnt_after_wr", if1.busy_cnt, 1);
      chk("sb_busy8_after", if0.rd_busy1, 0);

      // Reserve and write on the same edge
      t_se = 1; t_sa = 10;
      tick();
      chk("sim_cnt_a", if1.busy_cnt, 2);
      t_we = 1; t_wa = 10; t_wd = 32'hAB;
      tick();
      t_we = 0; t_se = 0; t_ra1 = 10;
      #1;
      chk("sim_same_cnt", if1.busy_cnt, 2);
      chk("sim_same_data", if0.rd_data1, 32'hAB);
      chk("sim_same_busy", if0.rd_busy1, 1);
      t_se = 1; t_sa = 12;
      tick();
      chk("sim_cnt_b", if1.busy_cnt, 3);
      t_sa = 11; t_we = 1; t_wa = 12; t_wd = 5;
      tick();
      t_we = 0; t_se = 0; t_ra1 = 11; t_ra2 = 12;
      #1;
      chk("sim_diff_cnt", if1.busy_cnt, 3);
      chk("sim_diff_busy11", if0.rd_busy1, 1);
      chk("sim_diff_busy12", if0.rd_busy2, 0);

      // Fill the whole scoreboard, then drain it
      t_se = 1;
      for (int r = 1; r < N; r++) begin
         t_sa = AW'(r);
         tick();
      end
      t_se = 0;
      #1 chk("full_cnt", if1.busy_cnt, 31);
      t_se = 1; t_sa = 31;
      tick();
      t_se = 0;
      #1 chk("full_rersv_cnt", if0.busy_cnt, 31);
      t_we = 1;
      for (int r = 1; r < N; r++) begin
         t_wa = AW'(r);
         t_wd = DW'(r * 3);
         tick();
      end
      t_we = 0;
      #1 chk("drain_cnt", if1.busy_cnt, 0);

      // Random traffic with occasional mid-cycle resets
      repeat (3000) begin
         rst   = ($urandom_range(0, 199) == 0);
         t_we  = ($urandom_range(0, 1) == 1);
         t_se  = ($urandom_range(0, 1) == 1);
         t_wa  = rnd_addr();
         t_sa  = ($urandom_range(0, 3) == 0) ? t_wa : rnd_addr();
         t_wd  = $urandom;
         t_ra1 = ($urandom_range(0, 3) == 0) ? t_wa : rnd_addr();
         t_ra2 = ($urandom_range(0, 3) == 0) ? t_wa : rnd_addr();
         tick();
      end
      rst = 1'b0; t_we = 0; t_se = 0;
      tick();
      tick();
      chk_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
